uart_prog_loader: RTL

- Upstream feeder of the single-cycle 8-bit processor's instruction memory.
- Receives a framed program image over UART_RXD, assembles 32-bit instruction words and writes them to a dual-port instruction RAM (replaces the fixed ROM image).
- Holds the CPU (PC and register file reset) while a load is in progress; releases it on a successful load.

---
 rtl/uart_prog_loader_if.sv | 11 +
 rtl/uart_prog_loader.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_prog_loader_if.sv
// Instruction-RAM write port driven by the program loader.
interface uart_prog_loader_if #(
    parameter int ADDR_W = 8
);
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (output imem_we, output imem_addr, output imem_wdata);
    modport slave  (input  imem_we, input  imem_addr, input  imem_wdata);
endinterface

// File: rtl/uart_prog_loader.sv
// UART 8N1 receiver plus framed program-image loader for the instruction RAM.
// Frame: A5, LEN (0 = 256 words), 4*LEN data bytes MSB first, XOR checksum.
module uart_prog_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_W       = 8,
    parameter int TIMEOUT_CYC  = 5000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rxd_i,
    input  logic              load_en_i,
    output logic              cpu_hold_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [ADDR_W:0]   words_loaded_o,
    uart_prog_loader_if.master imem
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TMO_M1  = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_st_e;
    typedef enum logic [2:0] {LD_IDLE, LD_HDR, LD_LEN, LD_DATA, LD_CSUM, LD_DONE, LD_ERR} ld_st_e;

    // ---------------- UART receiver ----------------
    logic          rxd_s1_q, rxd_s2_q, rxd_s3_q;
    rx_st_e        rx_st_q, rx_st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          rx_fall, byte_valid, frame_err;

    // s3 is the previous synchronized sample, used only for edge detection
    assign rx_fall = rxd_s3_q & ~rxd_s2_q;

    always_comb begin
        rx_st_d    = rx_st_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        sh_d       = sh_q;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        unique case (rx_st_q)
            RX_IDLE: if (rx_fall) begin
                rx_st_d = RX_START;
                cnt_d   = '0;
            end
            RX_START: if (cnt_q == HALF_M1) begin
                cnt_d   = '0;
                bit_d   = '0;
                rx_st_d = rxd_s2_q ? RX_IDLE : RX_DATA;
            end else cnt_d = cnt_q + 1'b1;
            RX_DATA: if (cnt_q == FULL_M1) begin
                cnt_d = '0;
                sh_d  = {rxd_s2_q, sh_q[7:1]};
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7) rx_st_d = RX_STOP;
            end else cnt_d = cnt_q + 1'b1;
            RX_STOP: if (cnt_q == FULL_M1) begin
                rx_st_d    = RX_IDLE;
                byte_valid = rxd_s2_q;
                frame_err  = ~rxd_s2_q;
            end else cnt_d = cnt_q + 1'b1;
            default: rx_st_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_s1_q <= 1'b1;
            rxd_s2_q <= 1'b1;
            rxd_s3_q <= 1'b1;
            rx_st_q  <= RX_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            sh_q     <= '0;
        end else begin
            rxd_s1_q <= rxd_i;
            rxd_s2_q <= rxd_s1_q;
            rxd_s3_q <= rxd_s2_q;
            rx_st_q  <= rx_st_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            sh_q     <= sh_d;
        end
    end

    // ---------------- Loader ----------------
    ld_st_e            ld_st_q, ld_st_d;
    logic              done_q, done_d, err_q, err_d;
    logic [ADDR_W:0]   wl_q, wl_d, n_q, n_d;
    logic [7:0]        acc_q, acc_d;
    logic [23:0]       word_q, word_d;
    logic [1:0]        bidx_q, bidx_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              tmo_active, timeout, go_err;

    assign tmo_active = (ld_st_q == LD_LEN) || (ld_st_q == LD_DATA) || (ld_st_q == LD_CSUM);
    assign timeout    = tmo_active && !byte_valid && (tmo_q == TMO_M1);

    always_comb begin
        ld_st_d = ld_st_q;
        done_d  = done_q;
        err_d   = err_q;
        wl_d    = wl_q;
        n_d     = n_q;
        acc_d   = acc_q;
        word_d  = word_q;
        bidx_d  = bidx_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        tmo_d   = (!tmo_active || byte_valid) ? '0 : tmo_q + 1'b1;
        go_err  = 1'b0;
        unique case (ld_st_q)
            LD_IDLE, LD_DONE, LD_ERR: if (load_en_i) begin
                ld_st_d = LD_HDR;
                done_d  = 1'b0;
                err_d   = 1'b0;
                wl_d    = '0;
                acc_d   = '0;
            end
            LD_HDR: begin
                if (frame_err) go_err = 1'b1;
                else if (byte_valid && sh_q == 8'hA5) ld_st_d = LD_LEN;
            end
            LD_LEN: begin
                if (frame_err || timeout) go_err = 1'b1;
                else if (byte_valid) begin
                    n_d     = (sh_q == 8'h00) ? (ADDR_W+1)'(256) : (ADDR_W+1)'(sh_q);
                    bidx_d  = '0;
                    ld_st_d = LD_DATA;
                end
            end
            LD_DATA: begin
                // wl_q already counts the word whose strobe is in flight, so the
                // exit happens only after that write cycle has completed
                if (frame_err || timeout) go_err = 1'b1;
                else if (wl_q == n_q) ld_st_d = LD_CSUM;
                else if (byte_valid) begin
                    acc_d  = acc_q ^ sh_q;
                    word_d = {word_q[15:0], sh_q};
                    bidx_d = bidx_q + 2'd1;
                    if (bidx_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = wl_q[ADDR_W-1:0];
                        wdata_d = {word_q, sh_q};
                        wl_d    = wl_q + 1'b1;
                    end
                end
            end
            LD_CSUM: begin
                if (frame_err || timeout) go_err = 1'b1;
                else if (byte_valid) begin
                    if (sh_q == acc_q) begin
                        ld_st_d = LD_DONE;
                        done_d  = 1'b1;
                    end else go_err = 1'b1;
                end
            end
            default: ld_st_d = LD_IDLE;
        endcase
        if (go_err) begin
            ld_st_d = LD_ERR;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_st_q <= LD_IDLE;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            wl_q    <= '0;
            n_q     <= '0;
            acc_q   <= '0;
            word_q  <= '0;
            bidx_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            tmo_q   <= '0;
        end else begin
            ld_st_q <= ld_st_d;
            done_q  <= done_d;
            err_q   <= err_d;
            wl_q    <= wl_d;
            n_q     <= n_d;
            acc_q   <= acc_d;
            word_q  <= word_d;
            bidx_q  <= bidx_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            tmo_q   <= tmo_d;
        end
    end

    assign busy_o         = (ld_st_q == LD_HDR) || tmo_active;
    assign cpu_hold_o     = busy_o || (ld_st_q == LD_ERR);
    assign done_o         = done_q;
    assign err_o          = err_q;
    assign words_loaded_o = wl_q;
    assign imem.imem_we    = we_q;
    assign imem.imem_addr  = addr_q;
    assign imem.imem_wdata = wdata_q;
endmodule
